morse_round_ctrl: RTL
=====================

# morse_round_ctrl

Game-round sequencer for the Morse game. It fetches each expected Morse code from the pattern ROM and opens a ten-second answer window on the existing ten-second timer chain. It then judges the player's decoded answer, or a timeout, and keeps score and lives until the game ends. It sits between the top-level game FSM/UI, the pattern ROM, and the ten-second timer, which it drives through that timer's enable and reset inputs.

## Interface
- ROM_AW, 5: pattern ROM address width; round index wraps modulo 2^ROM_AW.
- NUM_ROUNDS, 16: rounds per game, 1..2^ROM_AW.
- START_LIVES, 3: lives loaded at game start, 1..3.

- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that starts a game; honoured only in IDLE or OVER.
- ans_valid  in  1  one-cycle pulse marking that ans_code is valid.
- ans_code  in  4  player's decoded Morse symbol code.
- rom_addr  out  ROM_AW  pattern ROM address (registered).
- rom_data  in  4  expected code; valid one cycle after rom_addr changes.
- tmr_en  out  1  timer enable; high only in WAIT.
- tmr_clr  out  1  timer reset; high in FETCH and LOAD.
- tmr_timeout  in  1  ten-second timeout from the timer chain; level or pulse, sampled only in WAIT.
- busy  out  1  high in every state except IDLE and OVER.
- round_done  out  1  one-cycle pulse, high during NEXT.
- result_correct  out  1  result of the last judged round; held until the next judgement.
- score  out  8  correct answers in this game; saturates at 255.
- lives  out  2  remaining lives.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, FETCH, LOAD, WAIT, JUDGE, NEXT, OVER.
- IDLE: start moves to FETCH and initialises the game:
  - score=0, lives=START_LIVES, round=0, rom_addr=0, result_correct=0.
- FETCH: rom_addr holds the round index; tmr_clr=1. Always moves to LOAD.
- LOAD: expected<=rom_data; tmr_clr=1. Always moves to WAIT.
- WAIT: tmr_en=1.
  - ans_valid moves to JUDGE with verdict = (ans_code==expected).
  - tmr_timeout with no ans_valid moves to JUDGE with verdict = wrong.
  - ans_valid and tmr_timeout in the same cycle: the answer wins.
  - Otherwise stay in WAIT.
- JUDGE: apply the verdict, then move to NEXT.
  - Correct: score+1, saturating at 255.
  - Wrong: lives-1; never below 0.
  - In both cases result_correct<=verdict and round<=round+1.
- NEXT: round_done=1.
  - Move to OVER if lives==0 or round==NUM_ROUNDS.
  - Otherwise set rom_addr<=round (mod 2^ROM_AW) and move to FETCH.
- OVER: game_over=1; score, lives and result_correct hold. start re-initialises the game exactly as from IDLE.
- Events ignored: ans_valid outside WAIT; start outside IDLE/OVER; tmr_timeout outside WAIT.
- rst in any state returns to IDLE with every register cleared. A game in progress is abandoned and nothing is reported.

## Timing
- Reset values: state=IDLE, rom_addr=0, tmr_en=0, tmr_clr=0, busy=0, round_done=0, result_correct=0, score=0, lives=0, game_over=0.
- All outputs are registered or decoded from state; no combinational input-to-output paths.
- With start sampled at edge 0:
  - FETCH occupies cycle 1, LOAD cycle 2, WAIT from cycle 3.
  - tmr_en first high in cycle 3; tmr_clr high in cycles 1–2.
- An answer sampled in WAIT at edge n gives:
  - JUDGE in cycle n+1; tmr_en low from cycle n+1.
  - score, lives, result_correct and round_done all updated/high in cycle n+2 (NEXT).
  - FETCH in cycle n+3, or OVER (game_over high) in cycle n+3.
- Round overhead outside WAIT: 4 cycles (JUDGE, NEXT, FETCH, LOAD).
- The timer is cleared for at least 2 cycles before every WAIT, so each window is a full ten seconds.

## Test plan
- Reset, then START_LIVES=3 and start pulse; ROM[0]=4'h5; ans_code=5 in cycle 10 -> round_done in cycle 12, score=1, lives=3, result_correct=1, rom_addr=1 in cycle 13.
- Wrong answer (ans_code=4'h2 vs expected 4'h7) -> lives 3→2, score unchanged, result_correct=0.
- No answer with tmr_timeout pulsed in WAIT -> judged wrong; tmr_en drops the next cycle; tmr_clr high for 2 cycles before the next WAIT.
- ans_valid and tmr_timeout in the same WAIT cycle with the correct code -> correct verdict; score increments; lives unchanged.
- Three consecutive timeouts -> lives reaches 0; OVER entered with game_over=1 and busy=0.
- NUM_ROUNDS=16, all answers correct -> OVER after round 16 with score=16.
- OVER, then start -> score=0, lives=3, rom_addr=0.
- rst asserted mid-WAIT -> IDLE next cycle, all outputs at reset values.
- ans_valid pulses during FETCH or LOAD -> ignored; score and lives unchanged.

Source files
------------

// File: rtl/morse_round_ctrl_if.sv
// Pattern-ROM and ten-second-timer bus for the Morse round sequencer.
//   rom_addr    : controller -> ROM, address of the expected code
//   rom_data    : ROM -> controller, expected code (valid one cycle after rom_addr)
//   tmr_en      : controller -> timer, count enable for the answer window
//   tmr_clr     : controller -> timer, clears the timer chain
//   tmr_timeout : timer -> controller, ten-second window expired
// master = round controller side, slave = ROM/timer side.
interface morse_round_ctrl_if #(
  parameter int ROM_AW = 5
);
  logic [ROM_AW-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic              tmr_en;
  logic              tmr_clr;
  logic              tmr_timeout;

  modport master (
    output rom_addr, tmr_en, tmr_clr,
    input  rom_data, tmr_timeout
  );

  modport slave (
    input  rom_addr, tmr_en, tmr_clr,
    output rom_data, tmr_timeout
  );
endinterface

// File: rtl/morse_round_ctrl.sv
// Morse game round sequencer: fetches the expected code for each round,
// opens a ten-second answer window, judges the answer or timeout, and keeps
// score and lives until the game ends.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   bus (master)      : pattern ROM address/data and timer enable/clear/timeout
//   start_i           : one-cycle game start pulse (IDLE/OVER only)
//   ans_valid_i       : one-cycle pulse qualifying ans_code_i
//   ans_code_i        : player's decoded symbol code
//   busy_o            : game in progress (not IDLE/OVER)
//   round_done_o      : one-cycle pulse at the end of each round
//   result_correct_o  : verdict of the last judged round
//   score_o, lives_o  : correct answers (saturating) and remaining lives
//   game_over_o       : game has ended
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | rom_addr holds round index, timer cleared
// LOAD   | capture expected code, timer cleared
// WAIT   | answer window open, timer counting
// JUDGE  | apply verdict to score/lives
// NEXT   | round_done pulse, decide next round or game end
// OVER   | game ended, results held until start
module morse_round_ctrl #(
  parameter int ROM_AW      = 5,
  parameter int NUM_ROUNDS  = 16,
  parameter int START_LIVES = 3
) (
  input  logic                clk,
  input  logic                rst,
  morse_round_ctrl_if.master  bus,
  input  logic                start_i,
  input  logic                ans_valid_i,
  input  logic [3:0]          ans_code_i,
  output logic                busy_o,
  output logic                round_done_o,
  output logic                result_correct_o,
  output logic [7:0]          score_o,
  output logic [1:0]          lives_o,
  output logic                game_over_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_JUDGE, S_NEXT, S_OVER
  } state_t;

  // one extra bit so the round counter can reach NUM_ROUNDS == 2^ROM_AW
  localparam int            RW         = ROM_AW + 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);
  localparam logic [1:0]    INIT_LIVES = 2'(START_LIVES);

  state_t            state_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [RW-1:0]     round_q;
  logic [3:0]        expected_q;
  logic              verdict_q;
  logic [7:0]        score_q;
  logic [1:0]        lives_q;
  logic              result_q;
  logic              tmr_en_q;
  logic              tmr_clr_q;
  logic              busy_q;
  logic              round_done_q;
  logic              game_over_q;
  logic              verdict_d;

  // a timeout without an answer leaves ans_valid_i low, which yields "wrong"
  assign verdict_d = ans_valid_i && (ans_code_i == expected_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      round_q      <= '0;
      expected_q   <= '0;
      verdict_q    <= 1'b0;
      score_q      <= '0;
      lives_q      <= '0;
      result_q     <= 1'b0;
      tmr_en_q     <= 1'b0;
      tmr_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_i) begin
            score_q     <= '0;
            lives_q     <= INIT_LIVES;
            round_q     <= '0;
            rom_addr_q  <= '0;
            result_q    <= 1'b0;
            tmr_clr_q   <= 1'b1;
            busy_q      <= 1'b1;
            game_over_q <= 1'b0;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          expected_q <= bus.rom_data;
          tmr_clr_q  <= 1'b0;
          tmr_en_q   <= 1'b1;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (ans_valid_i || bus.tmr_timeout) begin
            verdict_q <= verdict_d;
            tmr_en_q  <= 1'b0;
            state_q   <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          if (verdict_q) begin
            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
          end else if (lives_q != 2'd0) begin
            lives_q <= lives_q - 2'd1;
          end
          result_q     <= verdict_q;
          round_q      <= round_q + 1'b1;
          round_done_q <= 1'b1;
          state_q      <= S_NEXT;
        end
        S_NEXT: begin
          round_done_q <= 1'b0;
          if (lives_q == 2'd0 || round_q == LAST_ROUND) begin
            busy_q      <= 1'b0;
            game_over_q <= 1'b1;
            state_q     <= S_OVER;
          end else begin
            rom_addr_q <= round_q[ROM_AW-1:0];
            tmr_clr_q  <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.tmr_en       = tmr_en_q;
  assign bus.tmr_clr      = tmr_clr_q;
  assign busy_o           = busy_q;
  assign round_done_o     = round_done_q;
  assign result_correct_o = result_q;
  assign score_o          = score_q;
  assign lives_o          = lives_q;
  assign game_over_o      = game_over_q;

endmodule
